// File: rtl/dphy_tx_lane_sequencer_if.sv
// Host/lane-side signal bundle for the D-PHY TX lane sequencer.
// master = register block and lane instances, slave = the sequencer.
interface dphy_tx_lane_sequencer_if #(
    parameter int LANES   = 4,
    parameter int IDLE_W  = 8,
    parameter int TIMER_W = 16
);
    logic               lines_enable;
    logic               clock_enable;
    logic               clock_continuous;
    logic               ulps_request;
    logic [3:0]         reg_lanes_number;
    logic [IDLE_W-1:0]  idle_timeout;
    logic [TIMER_W-1:0] wakeup_timeout;
    logic [LANES-1:0]   data_pending;
    logic [LANES-1:0]   lane_active;
    logic [LANES-1:0]   lane_ready;
    logic               clk_lane_active;

    logic [LANES-1:0]   lane_enable;
    logic               clk_start_rqst;
    logic               clk_fin_rqst;
    logic               data_hold;
    logic               ulps_enter;
    logic               ulps_exit_mark;
    logic               lines_ready;
    logic               clock_ready;
    logic               lines_active;
    logic               ulps_active;
    logic [3:0]         state_dbg;

    modport master (
        output lines_enable, clock_enable, clock_continuous,
        output ulps_request, reg_lanes_number, idle_timeout,
        output wakeup_timeout, data_pending, lane_active,
        output lane_ready, clk_lane_active,
        input  lane_enable, clk_start_rqst, clk_fin_rqst,
        input  data_hold, ulps_enter, ulps_exit_mark,
        input  lines_ready, clock_ready, lines_active,
        input  ulps_active, state_dbg
    );

    modport slave (
        input  lines_enable, clock_enable, clock_continuous,
        input  ulps_request, reg_lanes_number, idle_timeout,
        input  wakeup_timeout, data_pending, lane_active,
        input  lane_ready, clk_lane_active,
        output lane_enable, clk_start_rqst, clk_fin_rqst,
        output data_hold, ulps_enter, ulps_exit_mark,
        output lines_ready, clock_ready, lines_active,
        output ulps_active, state_dbg
    );
endinterface

// File: rtl/dphy_tx_lane_sequencer.sv
// D-PHY TX lane-group power/clock sequencer for LANES data lanes.
// Define DPHY_TX_ULPS_EN to build the ULPS entry/exit states.
module dphy_tx_lane_sequencer #(
    parameter int LANES   = 4,
    parameter int IDLE_W  = 8,
    parameter int TIMER_W = 16
) (
    input  logic                           clk_phy,
    input  logic                           rst,
    dphy_tx_lane_sequencer_if.slave        bus
);
    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_ENABLE    = 4'd1,
        ST_PARKED    = 4'd2,
        ST_CLK_START = 4'd3,
        ST_ACTIVE    = 4'd4,
        ST_DRAIN     = 4'd5,
        ST_CLK_STOP  = 4'd6,
`ifdef DPHY_TX_ULPS_EN
        ST_ULPS      = 4'd7,
        ST_WAKEUP    = 4'd8,
`endif
        ST_DISABLE   = 4'd9
    } state_t;

    localparam logic [3:0] LANES_N = 4'(LANES);

    state_t             state_q, state_d;
    logic [LANES-1:0]   mask_q, mask_d, mask_new;
    logic [IDLE_W-1:0]  idle_cnt_q, idle_cnt_d;
    logic [LANES-1:0]   lane_enable_q, lane_enable_d;
    logic               clk_start_q, clk_start_d;
    logic               clk_fin_q, clk_fin_d;
    logic               data_hold_q, data_hold_d;
    logic               lines_ready_q, lines_ready_d;
    logic               clock_ready_q, clock_ready_d;
    logic               lines_active_q, lines_active_d;
    logic [3:0]         lanes_n;
    logic               ready_all, ready_none;
    logic               pending_any, busy_any, idle_hit;
    logic               ulps_req;

    always_comb begin
        lanes_n = bus.reg_lanes_number;
        if (lanes_n == 4'd0)
            lanes_n = 4'd1;
        else if (lanes_n > LANES_N)
            lanes_n = LANES_N;
        mask_new = '0;
        for (int i = 0; i < LANES; i++)
            mask_new[i] = 4'(i) < lanes_n;
    end

    // Unmasked lanes are forced out of every lane condition here.
    assign ready_all   = &(bus.lane_ready | ~mask_q);
    assign ready_none  = ~|(bus.lane_ready & mask_q);
    assign pending_any = |(bus.data_pending & mask_q);
    assign busy_any    = |(bus.lane_active & mask_q);
    assign idle_hit    = !pending_any && !busy_any
                         && (idle_cnt_q >= bus.idle_timeout);

`ifdef DPHY_TX_ULPS_EN
    logic [TIMER_W-1:0] wake_cnt_q, wake_cnt_d;
    logic               ulps_enter_q, ulps_enter_d;
    logic               ulps_mark_q, ulps_mark_d;
    logic               ulps_active_q, ulps_active_d;
    assign ulps_req = bus.ulps_request;
`else
    logic unused_ulps;
    assign ulps_req    = 1'b0;
    assign unused_ulps = ^{bus.ulps_request, bus.wakeup_timeout};
`endif

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:
                if (bus.lines_enable) state_d = ST_ENABLE;
            ST_ENABLE:
                if (!bus.lines_enable) state_d = ST_DISABLE;
                else if (ready_all)    state_d = ST_PARKED;
            ST_PARKED:
                if (!bus.lines_enable) state_d = ST_DISABLE;
`ifdef DPHY_TX_ULPS_EN
                else if (ulps_req)     state_d = ST_ULPS;
`endif
                else if (bus.clock_enable
                         && (bus.clock_continuous || pending_any))
                    state_d = ST_CLK_START;
            ST_CLK_START:
                if (bus.clk_lane_active) state_d = ST_ACTIVE;
            ST_ACTIVE:
                if (!bus.lines_enable || ulps_req || !bus.clock_enable
                    || (!bus.clock_continuous && idle_hit))
                    state_d = ST_DRAIN;
            ST_DRAIN:
                if (!busy_any) state_d = ST_CLK_STOP;
            ST_CLK_STOP:
                if (!bus.clk_lane_active) state_d = ST_PARKED;
`ifdef DPHY_TX_ULPS_EN
            ST_ULPS:
                if (!ulps_req || !bus.lines_enable) state_d = ST_WAKEUP;
            ST_WAKEUP:
                if (wake_cnt_q == '0) state_d = ST_PARKED;
`endif
            ST_DISABLE:
                if (ready_none) state_d = ST_IDLE;
            default:
                state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        mask_d = mask_q;
        if (state_q == ST_IDLE && state_d == ST_ENABLE)
            mask_d = mask_new;

        idle_cnt_d = '0;
        if (state_q == ST_ACTIVE && !pending_any && !busy_any)
            idle_cnt_d = (idle_cnt_q == '1) ? idle_cnt_q : idle_cnt_q + 1'b1;

        // Outputs follow the state being entered so they line up with state_q.
        lane_enable_d  = (state_d inside {ST_IDLE, ST_DISABLE}) ? '0 : mask_d;
        clk_start_d    = state_d == ST_CLK_START;
        clk_fin_d      = state_d == ST_CLK_STOP && state_q != ST_CLK_STOP;
        data_hold_d    = state_d inside {ST_PARKED, ST_CLK_START,
                                         ST_DRAIN, ST_CLK_STOP};
        lines_ready_d  = state_d inside {ST_PARKED, ST_CLK_START, ST_ACTIVE,
                                         ST_DRAIN, ST_CLK_STOP};
        clock_ready_d  = state_d == ST_ACTIVE;
        lines_active_d = busy_any;
`ifdef DPHY_TX_ULPS_EN
        wake_cnt_d = wake_cnt_q;
        if (state_d == ST_WAKEUP && state_q != ST_WAKEUP)
            wake_cnt_d = bus.wakeup_timeout;
        else if (state_q == ST_WAKEUP && wake_cnt_q != '0)
            wake_cnt_d = wake_cnt_q - 1'b1;
        ulps_enter_d  = state_d inside {ST_ULPS, ST_WAKEUP};
        ulps_mark_d   = state_d == ST_WAKEUP;
        ulps_active_d = state_q == ST_ULPS && state_d == ST_ULPS;
`endif
    end

    always_ff @(posedge clk_phy) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            mask_q         <= '0;
            idle_cnt_q     <= '0;
            lane_enable_q  <= '0;
            clk_start_q    <= 1'b0;
            clk_fin_q      <= 1'b0;
            data_hold_q    <= 1'b0;
            lines_ready_q  <= 1'b0;
            clock_ready_q  <= 1'b0;
            lines_active_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            mask_q         <= mask_d;
            idle_cnt_q     <= idle_cnt_d;
            lane_enable_q  <= lane_enable_d;
            clk_start_q    <= clk_start_d;
            clk_fin_q      <= clk_fin_d;
            data_hold_q    <= data_hold_d;
            lines_ready_q  <= lines_ready_d;
            clock_ready_q  <= clock_ready_d;
            lines_active_q <= lines_active_d;
        end
    end

`ifdef DPHY_TX_ULPS_EN
    always_ff @(posedge clk_phy) begin
        if (rst) begin
            wake_cnt_q    <= '0;
            ulps_enter_q  <= 1'b0;
            ulps_mark_q   <= 1'b0;
            ulps_active_q <= 1'b0;
        end else begin
            wake_cnt_q    <= wake_cnt_d;
            ulps_enter_q  <= ulps_enter_d;
            ulps_mark_q   <= ulps_mark_d;
            ulps_active_q <= ulps_active_d;
        end
    end

    assign bus.ulps_enter     = ulps_enter_q;
    assign bus.ulps_exit_mark = ulps_mark_q;
    assign bus.ulps_active    = ulps_active_q;
`else
    assign bus.ulps_enter     = 1'b0;
    assign bus.ulps_exit_mark = 1'b0;
    assign bus.ulps_active    = 1'b0;
`endif

    assign bus.lane_enable    = lane_enable_q;
    assign bus.clk_start_rqst = clk_start_q;
    assign bus.clk_fin_rqst   = clk_fin_q;
    assign bus.data_hold      = data_hold_q;
    assign bus.lines_ready    = lines_ready_q;
    assign bus.clock_ready    = clock_ready_q;
    assign bus.lines_active   = lines_active_q;
    assign bus.state_dbg      = state_q;
endmodule

// File: tb/tb_dphy_tx_lane_sequencer.sv
// Directed bench for dphy_tx_lane_sequencer (LANES=4).
// ULPS checks run only when DPHY_TX_ULPS_EN is defined.
module tb_dphy_tx_lane_sequencer;
    localparam logic [3:0] S_IDLE = 4'd0, S_ENABLE = 4'd1, S_PARKED = 4'd2;
    localparam logic [3:0] S_CLK_START = 4'd3, S_ACTIVE = 4'd4;
    localparam logic [3:0] S_DRAIN = 4'd5, S_CLK_STOP = 4'd6;
    localparam logic [3:0] S_ULPS = 4'd7, S_WAKEUP = 4'd8, S_DISABLE = 4'd9;

    logic clk_phy = 1'b0;
    logic rst;
    int   total = 0;
    int   bad = 0;
    int   n;

    dphy_tx_lane_sequencer_if #(.LANES(4), .IDLE_W(8), .TIMER_W(16)) bus ();

    dphy_tx_lane_sequencer #(.LANES(4), .IDLE_W(8), .TIMER_W(16)) dut (
        .clk_phy (clk_phy),
        .rst     (rst),
        .bus     (bus)
    );

    always #5 clk_phy = ~clk_phy;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_phy);
        #1;
    endtask

    function automatic logic [16:0] all_outs();
        return {bus.lane_enable, bus.clk_start_rqst, bus.clk_fin_rqst,
                bus.data_hold, bus.ulps_enter, bus.ulps_exit_mark,
                bus.lines_ready, bus.clock_ready, bus.lines_active,
                bus.ulps_active, bus.state_dbg};
    endfunction

    initial begin
        rst = 1'b1;
        bus.lines_enable = 0; bus.clock_enable = 0;
        bus.clock_continuous = 0; bus.ulps_request = 0;
        bus.reg_lanes_number = 0; bus.idle_timeout = 0;
        bus.wakeup_timeout = 0; bus.data_pending = 0;
        bus.lane_active = 0; bus.lane_ready = 0;
        bus.clk_lane_active = 0;
        tick(); tick();
        chk("reset_outs", all_outs(), 0);

        // power-up with 2 of 4 lanes
        rst = 1'b0;
        bus.reg_lanes_number = 2; bus.lines_enable = 1;
        tick();
        chk("enable_state", bus.state_dbg, S_ENABLE);
        chk("enable_mask", bus.lane_enable, 4'b0011);
        bus.lane_ready = 4'b0001;
        tick();
        chk("partial_ready", bus.state_dbg, S_ENABLE);
        chk("partial_lr", bus.lines_ready, 0);
        bus.lane_ready = 4'b0011;
        tick();
        chk("parked", bus.state_dbg, S_PARKED);
        chk("parked_lr", bus.lines_ready, 1);
        chk("parked_hold", bus.data_hold, 1);

        // continuous clock start
        bus.clock_continuous = 1; bus.clock_enable = 1;
        tick();
        chk("clk_start", bus.clk_start_rqst, 1);
        tick();
        chk("clk_start_wait", bus.state_dbg, S_CLK_START);
        bus.clk_lane_active = 1;
        tick();
        chk("active", bus.state_dbg, S_ACTIVE);
        chk("active_ready", bus.clock_ready, 1);
        chk("active_hold", bus.data_hold, 0);
        chk("active_start", bus.clk_start_rqst, 0);

        // clock_enable drop with lane 1 mid-burst
        bus.clock_enable = 0; bus.lane_active = 4'b0010;
        tick();
        chk("drain", bus.state_dbg, S_DRAIN);
        chk("drain_hold", bus.data_hold, 1);
        chk("drain_fin", bus.clk_fin_rqst, 0);
        chk("drain_la", bus.lines_active, 1);
        bus.clock_enable = 1;
        tick();
        chk("drain_stay", bus.state_dbg, S_DRAIN);
        bus.lane_active = 0;
        tick();
        chk("stop_fin", bus.clk_fin_rqst, 1);
        chk("stop_state", bus.state_dbg, S_CLK_STOP);
        bus.clock_continuous = 0; bus.idle_timeout = 5;
        tick();
        chk("stop_fin_pulse", bus.clk_fin_rqst, 0);
        bus.clk_lane_active = 0;
        tick();
        chk("back_parked", bus.state_dbg, S_PARKED);

        // unmasked pending lane must not start the clock
        bus.data_pending = 4'b0100;
        tick();
        chk("unmasked_pend", bus.state_dbg, S_PARKED);
        bus.data_pending = 4'b0001;
        tick();
        chk("pend_start", bus.state_dbg, S_CLK_START);
        bus.data_pending = 0; bus.clk_lane_active = 1;
        n = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (bus.state_dbg != S_ACTIVE) break;
            n++;
        end
        chk("idle_cycles", n, 6);
        chk("idle_drain", bus.state_dbg, S_DRAIN);
        tick();
        chk("idle_fin", bus.clk_fin_rqst, 1);
        tick();
        chk("idle_fin_once", bus.clk_fin_rqst, 0);
        bus.clk_lane_active = 0;
        tick();
        chk("idle_parked", bus.state_dbg, S_PARKED);

        // idle_timeout = 0 stops on the first idle cycle
        bus.data_pending = 4'b0001; bus.idle_timeout = 0;
        tick();
        bus.data_pending = 0; bus.clk_lane_active = 1;
        tick();
        chk("to0_active", bus.state_dbg, S_ACTIVE);
        tick();
        chk("to0_drain", bus.state_dbg, S_DRAIN);
        tick();
        bus.clk_lane_active = 0;
        tick();
        chk("to0_parked", bus.state_dbg, S_PARKED);

`ifdef DPHY_TX_ULPS_EN
        // ULPS beats pending data
        bus.data_pending = 4'b0001; bus.ulps_request = 1;
        tick();
        chk("ulps_state", bus.state_dbg, S_ULPS);
        chk("ulps_enter", bus.ulps_enter, 1);
        chk("ulps_act0", bus.ulps_active, 0);
        bus.data_pending = 0; bus.clock_enable = 0;
        tick();
        chk("ulps_act1", bus.ulps_active, 1);
        bus.ulps_request = 0; bus.wakeup_timeout = 10;
        n = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (bus.ulps_exit_mark) n++;
            if (bus.state_dbg == S_PARKED) break;
        end
        chk("wake_cycles", n, 11);
        chk("wake_parked", bus.state_dbg, S_PARKED);
        chk("wake_enter0", bus.ulps_enter, 0);

        bus.ulps_request = 1;
        tick();
        bus.ulps_request = 0; bus.wakeup_timeout = 0;
        n = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (bus.ulps_exit_mark) n++;
            if (bus.state_dbg == S_PARKED) break;
        end
        chk("wake0_cycles", n, 1);

        bus.ulps_request = 1;
        tick();
        bus.ulps_request = 0; bus.wakeup_timeout = 10;
        tick();
        chk("pre_rst_wake", bus.state_dbg, S_WAKEUP);
        rst = 1;
        tick();
        chk("rst_wakeup", all_outs(), 0);
        rst = 0;
        tick(); tick();
        chk("reparked", bus.state_dbg, S_PARKED);
`else
        bus.ulps_request = 1; bus.clock_enable = 0;
        tick();
        chk("no_ulps", bus.state_dbg, S_PARKED);
        chk("no_ulps_out", bus.ulps_enter, 0);
        bus.ulps_request = 0;
`endif

        // reset from ACTIVE
        bus.clock_continuous = 1; bus.clock_enable = 1;
        bus.clk_lane_active = 0;
        tick();
        bus.clk_lane_active = 1;
        tick();
        chk("pre_rst_act", bus.state_dbg, S_ACTIVE);
        rst = 1;
        tick();
        chk("rst_active", all_outs(), 0);

        // mask clamp, and disable that ignores early re-enable
        rst = 0; bus.reg_lanes_number = 0;
        bus.clock_enable = 0; bus.clk_lane_active = 0;
        tick();
        chk("mask_n0", bus.lane_enable, 4'b0001);
        bus.lines_enable = 0;
        tick();
        chk("disable", bus.state_dbg, S_DISABLE);
        chk("disable_le", bus.lane_enable, 0);
        bus.lines_enable = 1;
        tick();
        chk("disable_hold", bus.state_dbg, S_DISABLE);
        bus.lane_ready = 4'b0010;
        tick();
        chk("disable_idle", bus.state_dbg, S_IDLE);
        bus.reg_lanes_number = 9;
        tick();
        chk("mask_n9", bus.lane_enable, 4'b1111);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/dphy_tx_lane_sequencer.md
# dphy_tx_lane_sequencer

Parametrised power/clock sequencer for the D-PHY TX lane group, generalising the fixed 4-lane turn-on controller to `LANES` data lanes. It sits between the DSI host register block and the per-lane `dsi_lane_full` instances plus the clock lane. It adds four behaviours to the existing on/off sequencing:
- waits on all masked lanes, not any;
- non-continuous clock with idle auto-stop;
- burst drain before clock stop;
- optional ULPS entry/exit with wakeup timer.

## Interface
- `LANES`, 4, number of data lanes (1..8)
- `IDLE_W`, 8, width of idle counter and `idle_timeout`
- `TIMER_W`, 16, width of wakeup counter and `wakeup_timeout`

- `clk_phy`  in  1  lane logic clock; all logic on rising edge
- `rst`  in  1  synchronous, active-high reset
- `lines_enable`  in  1  request LP buffers on (level)
- `clock_enable`  in  1  allow clock lane HS (level)
- `clock_continuous`  in  1  1 = clock held HS in ACTIVE; 0 = auto-stop on idle
- `ulps_request`  in  1  request ULPS (level)
- `reg_lanes_number`  in  4  active lane count; sampled on IDLE→ENABLE_LANES
- `idle_timeout`  in  IDLE_W  idle cycles before auto clock stop
- `wakeup_timeout`  in  TIMER_W  Mark-1 hold cycles on ULPS exit
- `data_pending`  in  LANES  per-lane FIFO non-empty
- `lane_active`  in  LANES  per-lane HS burst in progress
- `lane_ready`  in  LANES  per-lane LP buffers up
- `clk_lane_active`  in  1  clock lane running HS
- `lane_enable`  out  LANES  per-lane LP buffer enable
- `clk_start_rqst`  out  1  clock lane start (level)
- `clk_fin_rqst`  out  1  clock lane stop (1-cycle pulse)
- `data_hold`  out  1  forbids lane bridges from starting bursts
- `ulps_enter`  out  1  drive masked lanes and clock to ULPS
- `ulps_exit_mark`  out  1  drive Mark-1 during wakeup
- `lines_ready`, `clock_ready`, `lines_active`, `ulps_active`  out  1 each  status
- `state_dbg`  out  4  current FSM state encoding

## Operation
Lane mask:
- Lowest N bits set, where N = `reg_lanes_number` clamped to 1..`LANES` (0→1, >`LANES`→`LANES`).
- Latched only on IDLE→ENABLE_LANES.
- Unmasked lanes are ignored in every condition.

FSM states and transitions:
- **IDLE**
  - Exit: `lines_enable` → ENABLE_LANES.
- **ENABLE_LANES**
  - `lane_enable` = mask.
  - Exit: all masked lanes have `lane_ready` = 1 → PARKED.
  - `!lines_enable` → DISABLE.
- **PARKED** (clock in LP-11, `data_hold` = 1). Priority order:
  1. `!lines_enable` → DISABLE
  2. `ulps_request` → ULPS
  3. `clock_enable` && (`clock_continuous` || any masked `data_pending`) → CLK_START
- **CLK_START**
  - `clk_start_rqst` = 1.
  - Exit: `clk_lane_active` → ACTIVE.
- **ACTIVE**
  - `data_hold` = 0, `clock_ready` = 1.
  - Idle counter clears when any masked `data_pending` or `lane_active` is set; otherwise it increments, saturating.
  - Stop condition, → DRAIN: `!lines_enable` || `ulps_request` || `!clock_enable` || (`!clock_continuous` && idle && counter ≥ `idle_timeout`).
- **DRAIN**
  - `data_hold` = 1.
  - Exit: no masked `lane_active` → CLK_STOP.
- **CLK_STOP**
  - `clk_fin_rqst` pulses on the entry cycle only.
  - Exit: `!clk_lane_active` → PARKED. The original stop reason is re-evaluated there.
- **ULPS**
  - `ulps_enter` = 1; `ulps_active` = 1 from the next cycle.
  - Exit: `!ulps_request` || `!lines_enable` → WAKEUP.
- **WAKEUP**
  - `ulps_enter` = 1, `ulps_exit_mark` = 1.
  - Counter loads `wakeup_timeout` on entry and decrements.
  - Exit: counter = 0 → PARKED.
- **DISABLE**
  - `lane_enable` = 0.
  - Exit: no masked `lane_ready` → IDLE.
  - A `lines_enable` reassertion is honoured only after IDLE is reached.

## Timing
Reset values:
- All outputs are 0.
- `state_dbg` = IDLE.
- Mask = 0; counters = 0.

Output timing and latency:
- All outputs are registered and reflect `state_current`; 1-cycle latency from an input condition.
- `lines_ready` = 1 in PARKED, CLK_START, ACTIVE, DRAIN, CLK_STOP.
- `lines_active` = registered OR of masked `lane_active`.

Boundary behaviour:
- `idle_timeout` = 0: stop on the first idle cycle.
- Idle counter saturates at all-ones and never wraps.
- `wakeup_timeout` = 0: exactly 1 cycle in WAKEUP.
- `wakeup_timeout` = W: exactly W+1 cycles in WAKEUP.
- Simultaneous `ulps_request` and data in PARKED: ULPS wins.
- `clock_enable` toggled during DRAIN/CLK_STOP: the stop sequence always completes first.
- `rst` mid-operation: IDLE next cycle; all outputs 0, including mid-ULPS.

## Configuration
- `DPHY_TX_ULPS_EN` defined:
  - ULPS and WAKEUP states exist.
  - `ulps_request` participates in PARKED and ACTIVE transitions.
- Undefined:
  - ULPS and WAKEUP states are not compiled.
  - `ulps_request` and `wakeup_timeout` are ignored.
  - `ulps_enter`, `ulps_exit_mark`, `ulps_active` are tied 0.

## Test plan
- `LANES`=4, `reg_lanes_number`=2, `lines_enable`=1, `lane_ready`=4'b0001 then 4'b0011 → `lane_enable`=4'b0011; PARKED only after 4'b0011; `lines_ready`=1 one cycle later.
- Continuous clock, `clock_enable`=1 → `clk_start_rqst` until `clk_lane_active`; `clock_ready`=1; `data_hold`=0.
- `clock_continuous`=0, `idle_timeout`=5, no `data_pending` → ACTIVE left after 6 idle cycles; `clk_fin_rqst` single pulse; `data_pending`=4'b0001 restarts the clock.
- `clock_enable` drops while `lane_active`=4'b0010 → DRAIN with `data_hold`=1; `clk_fin_rqst` only after `lane_active`=0.
- ULPS build, `ulps_request` 1 then 0, `wakeup_timeout`=10 → `ulps_active`=1; `ulps_exit_mark` high exactly 11 cycles; returns to PARKED.
- `rst` asserted in WAKEUP and in ACTIVE → all outputs 0 and `state_dbg`=IDLE next cycle; `reg_lanes_number`=0 and =9 → masks 4'b0001 and 4'b1111.
